spike_encoder: RTL and testbench
================================

Name: spike_encoder

Overview:
Rate-codes a presented input pattern into a parallel spike vector for the neuron's `inputs` bus. The block sits directly upstream of the neuron.
- Intensities arrive serially over a valid/ready load port, one per channel.
- The block then plays out a fixed window of timesteps. Each channel emits a number of spikes equal to its intensity value.
- It drives the neuron's `learn` line for the duration of the window.

Parameters:
N_CH, 9, number of channels (width of the neuron input vector)
VAL_W, 4, bits per intensity value
WINDOW, 16, timesteps per presentation; must equal 2**VAL_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse: begin loading a new pattern
learn_en  input  1  sampled on accepted start; requests learning for this presentation
pix_data  input  VAL_W  intensity of the current channel
pix_valid  input  1  pix_data valid
pix_ready  output  1  block accepts pix_data this cycle
spikes  output  [0:N_CH-1]  spike vector; bit i drives neuron input i
spike_valid  output  1  spikes meaningful this cycle
learn_out  output  1  drives the neuron learn input
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of presentation

Behaviour:
- Reset: state=IDLE; all outputs 0; val[], acc[], channel index, step counter, learn latch cleared. Reset mid-operation aborts at once; there is no partial output afterwards.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 -> LOAD; latch learn_en; ch_idx=0; acc[] cleared.
  - pix_valid is ignored.
- LOAD:
  - pix_ready=1.
  - Each cycle with pix_valid&pix_ready writes val[ch_idx]=pix_data and increments ch_idx.
  - The transfer with ch_idx=N_CH-1 moves to RUN next cycle with step=0.
  - pix_valid low stalls with no timeout.
  - start is ignored.
- RUN (exactly WINDOW cycles, step 0..WINDOW-1): per channel, on each edge:
  - {carry, acc_next} = acc + val, computed at VAL_W+1 bits.
  - acc <= acc_next, a VAL_W-bit wrap.
  - spikes[i] <= carry.
  - spike_valid <= 1.
  - After step WINDOW-1 -> DONE.
- Spike count and position: over one window, channel i spikes exactly val[i] times, deterministically.
  - val=0 gives no spikes.
  - val=15 spikes in every valid cycle except the first.
  - val=1 spikes only in the last valid cycle.
- Output timing:
  - spike_valid is high in the WINDOW cycles starting the cycle after entering RUN, which includes the DONE cycle.
  - spikes is forced 0 whenever spike_valid=0.
- learn_out = latched learn_en while spike_valid=1; 0 otherwise.
- DONE: done=1 for one cycle, then IDLE. A start in the DONE cycle is ignored; start is accepted in IDLE only.
- Back-to-back presentations: start may be asserted in the first IDLE cycle after done.
- pix_ready is 0 outside LOAD; transfers outside LOAD are dropped.

Optional Feature:
SPIKE_ENC_LFSR_EN
- Defined:
  - Stochastic coding replaces the accumulator.
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded 16'hACE1 on reset and on every IDLE->LOAD transition. It advances once per RUN cycle.
  - Channel i compares a VAL_W-bit slice of the LFSR, rotated left by i, against val[i]: spikes[i] <= (slice < val[i]).
  - Spike count is statistical, but a repeated pattern yields an identical spike train.
  - val=0 never spikes.
- Undefined: deterministic accumulator coding as above.

Test Plan:
- Reset then idle: all outputs 0, busy=0, pix_ready=0 for 20 cycles with random pix_valid/pix_data.
- start+learn_en=1, load vals 0,1,2,4,8,15,15,7,3 with no stalls. Expected per-channel spike counts over the window are 0,1,2,4,8,15,15,7,3. spike_valid is high for exactly 16 cycles and learn_out equals spike_valid. done pulses once, coinciding with the 16th valid cycle.
- Bit-exact timing at val=8: channel spikes on valid cycles 2,4,...,16. At val=1: only valid cycle 16. At val=15: cycles 2-16.
- Load stalls: pix_valid low for 3 cycles between channels 4 and 5 -> values captured correctly and RUN entry delayed by 3 cycles. A start pulse during LOAD/RUN has no effect.
- Reset asserted at RUN step 7 -> next cycle spikes=0, spike_valid=0, state IDLE. A following start/load of all-4 pattern gives exactly 4 spikes per channel.
- With SPIKE_ENC_LFSR_EN: all-15 vs all-0 patterns -> the all-0 pattern gives zero spikes. Two identical consecutive presentations produce identical spikes traces.

Source files
------------

// File: rtl/spike_encoder.sv
// spike_encoder: loads N_CH intensities serially, then rate-codes them into WINDOW cycles of parallel spikes.
// Define SPIKE_ENC_LFSR_EN to replace accumulator coding with stochastic LFSR coding.
module spike_encoder #(
    parameter int N_CH   = 9,
    parameter int VAL_W  = 4,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             learn_en,
    input  logic [VAL_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [0:N_CH-1]  spikes,
    output logic             spike_valid,
    output logic             learn_out,
    output logic             busy,
    output logic             done
);
    localparam int              CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [VAL_W-1:0] STEP_LAST = VAL_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic [CH_W-1:0]  ch_idx;
    logic [VAL_W-1:0] step;
    logic             learn_lat;
    logic [VAL_W-1:0] val [N_CH];
    logic [0:N_CH-1]  spike_next;

`ifdef SPIKE_ENC_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr;

    function automatic logic [15:0] lfsr_advance(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Bit k of x rotated left by n is x[(k - n) mod 16], i.e. bit 16-n+k of {x, x}.
    function automatic logic [VAL_W-1:0] lfsr_slice(input logic [15:0] x, input int n);
        logic [31:0] xx;
        xx = {x, x};
        return xx[16 - (n % 16) +: VAL_W];
    endfunction

    always_comb begin
        spike_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            spike_next[i] = lfsr_slice(lfsr, i) < val[i];
        end
    end
`else
    logic [VAL_W-1:0] acc      [N_CH];
    logic [VAL_W-1:0] acc_next [N_CH];

    function automatic logic [VAL_W:0] acc_add(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // The carry out of each wrap is the spike: val carries happen per 2**VAL_W steps.
    always_comb begin
        spike_next = '0;
        acc_next   = '{default: '0};
        for (int i = 0; i < N_CH; i++) begin
            {spike_next[i], acc_next[i]} = acc_add(acc[i], val[i]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ch_idx      <= '0;
            step        <= '0;
            learn_lat   <= 1'b0;
            pix_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            learn_out   <= 1'b0;
            spikes      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                val[i] <= '0;
`ifndef SPIKE_ENC_LFSR_EN
                acc[i] <= '0;
`endif
            end
`ifdef SPIKE_ENC_LFSR_EN
            lfsr <= LFSR_SEED;
`endif
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            learn_out   <= 1'b0;
            spikes      <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        learn_lat <= learn_en;
                        ch_idx    <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
`ifdef SPIKE_ENC_LFSR_EN
                        lfsr <= LFSR_SEED;
`else
                        for (int i = 0; i < N_CH; i++) acc[i] <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (pix_valid) begin
                        val[ch_idx] <= pix_data;
                        if (ch_idx == CH_LAST) begin
                            state     <= RUN;
                            step      <= '0;
                            pix_ready <= 1'b0;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    spikes      <= spike_next;
                    spike_valid <= 1'b1;
                    learn_out   <= learn_lat;
                    step        <= step + 1'b1;
`ifdef SPIKE_ENC_LFSR_EN
                    lfsr <= lfsr_advance(lfsr);
`else
                    for (int i = 0; i < N_CH; i++) acc[i] <= acc_next[i];
`endif
                    if (step == STEP_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_encoder.sv
// Randomized self-checking bench for spike_encoder against a closed-form rate-coding model.
module tb_spike_encoder;
    localparam int N_CH   = 9;
    localparam int VAL_W  = 4;
    localparam int WINDOW = 16;

    typedef logic [VAL_W-1:0] val_arr_t [N_CH];

    logic             clk = 1'b0;
    logic             reset, start, learn_en, pix_valid;
    logic [VAL_W-1:0] pix_data;
    logic             pix_ready, spike_valid, learn_out, busy, done;
    logic [0:N_CH-1]  spikes;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [0:N_CH-1] trace      [WINDOW];
    logic [0:N_CH-1] prev_trace [WINDOW];

    spike_encoder #(.N_CH(N_CH), .VAL_W(VAL_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .reset(reset), .start(start), .learn_en(learn_en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .spikes(spikes), .spike_valid(spike_valid), .learn_out(learn_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel with value v has emitted floor(k*v/WINDOW) spikes after k valid cycles.
    function automatic logic [WINDOW-1:0] model_mask(input int v);
        logic [WINDOW-1:0] m;
        for (int k = 1; k <= WINDOW; k++)
            m[k-1] = ((k * v) / WINDOW) != (((k - 1) * v) / WINDOW);
        return m;
    endfunction

    task automatic present(input val_arr_t v, input logic lrn, input int stall_ch,
                           input int stall_len, input int abort_at, input bit cmp_prev);
        int t0, first_v, nv, done_cnt, done_at;
        logic [WINDOW-1:0] obs;
        @(posedge clk); #1;
        start = 1'b1; learn_en = lrn; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; learn_en = 1'($urandom);
        for (int c = 0; c < N_CH; c++) begin
            if (c == stall_ch) begin
                for (int s = 0; s < stall_len; s++) begin
                    pix_valid = 1'b0; pix_data = VAL_W'($urandom); start = (s == 0);
                    @(negedge clk);
                    check("ready_stall", 32'(pix_ready), 32'd1);
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            pix_valid = 1'b1; pix_data = v[c];
            @(negedge clk);
            check("ready_load", 32'(pix_ready), 32'd1);
            check("valid_load", 32'(spike_valid), 32'd0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        nv = 0; first_v = -1; done_cnt = 0; done_at = 0;
        for (int k = 0; k < 60 && done_cnt == 0; k++) begin
            @(negedge clk);
            if (spike_valid) begin
                if (first_v < 0) first_v = cyc;
                if (nv < WINDOW) trace[nv] = spikes;
                nv++;
            end else begin
                check("spikes_gated", 32'(spikes), 32'd0);
            end
            check("learn_out", 32'(learn_out), 32'(spike_valid & lrn));
            check("ready_run", 32'(pix_ready), 32'd0);
            if (done) begin
                done_cnt++;
                done_at = nv;
            end
            if (abort_at > 0 && nv == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort_spikes", 32'(spikes), 32'd0);
                check("abort_valid", 32'(spike_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_learn", 32'(learn_out), 32'd0);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            pix_valid = 1'($urandom); pix_data = VAL_W'($urandom);
            start = done || (nv == 5);
        end
        @(negedge clk);
        start = 1'b0; pix_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(spike_valid), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("valid_count", 32'(nv), 32'(WINDOW));
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_at", 32'(done_at), 32'(WINDOW));
        check("first_valid", 32'(first_v), 32'(t0 + N_CH + 2 + stall_len));
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < WINDOW; k++) obs[k] = trace[k][c];
`ifdef SPIKE_ENC_LFSR_EN
            if (v[c] == 0) check($sformatf("zero_ch%0d", c), 32'(obs), 32'd0);
`else
            check($sformatf("mask_ch%0d", c), 32'(obs), 32'(model_mask(int'(v[c]))));
            check($sformatf("count_ch%0d", c), 32'($countones(obs)), 32'(v[c]));
`endif
        end
        if (cmp_prev)
            for (int k = 0; k < WINDOW; k++)
                check($sformatf("repeat_t%0d", k), 32'(trace[k]), 32'(prev_trace[k]));
        for (int k = 0; k < WINDOW; k++) prev_trace[k] = trace[k];
    endtask

    initial begin
        val_arr_t p;
        int base [N_CH] = '{0, 1, 2, 4, 8, 15, 15, 7, 3};
        reset = 1'b1; start = 1'b0; learn_en = 1'b0; pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'($urandom); pix_data = VAL_W'($urandom);
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ready", 32'(pix_ready), 32'd0);
            check("rst_outs", 32'({spikes, spike_valid, learn_out, done}), 32'd0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;

        for (int c = 0; c < N_CH; c++) p[c] = VAL_W'(base[c]);
        present(p, 1'b1, -1, 0, 0, 1'b0);

        for (int c = 0; c < N_CH; c++) p[c] = VAL_W'($urandom);
        present(p, 1'b0, 5, 3, 0, 1'b0);

        for (int c = 0; c < N_CH; c++) p[c] = VAL_W'($urandom);
        present(p, 1'b1, -1, 0, 7, 1'b0);
        for (int c = 0; c < N_CH; c++) p[c] = VAL_W'(4);
        present(p, 1'b1, -1, 0, 0, 1'b0);

        for (int c = 0; c < N_CH; c++) p[c] = VAL_W'(15);
        present(p, 1'b0, -1, 0, 0, 1'b0);
        for (int c = 0; c < N_CH; c++) p[c] = '0;
        present(p, 1'b1, -1, 0, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < N_CH; c++) p[c] = VAL_W'($urandom);
            present(p, 1'($urandom), int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 4)), 0, 1'b0);
            present(p, 1'($urandom), -1, 0, 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
